prefetch_buffer: RTL and testbench

//  Instruction prefetch unit between memory_controller and instruction_fetch.

---
 rtl/prefetch_buffer_if.sv | 46 ++++
 rtl/prefetch_buffer.sv | 141 ++++++++++++++
 tb/tb_prefetch_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_buffer_if.sv
// Prefetch buffer bus bundle: the processor memory request/response bus
// plus the valid/ready instruction channel towards the fetch stage and the
// redirect (flush) request.
interface prefetch_buffer_if #(
  parameter int DEPTH = 4
);
  // Redirect
  logic        flush_i;
  logic [31:0] flush_pc_i;
  // Memory request / response
  logic [31:0] addr_o;
  logic [1:0]  trans_o;
  logic        write_o;
  logic        size_o;
  logic [1:0]  prot_o;
  logic [31:0] rdata_i;
  logic        data_valid_i;
  logic        abort_i;
  // Fetch-stage channel
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_abort_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  // The prefetch unit side
  modport master (
    input  flush_i, flush_pc_i,
    output addr_o, trans_o, write_o, size_o, prot_o,
    input  rdata_i, data_valid_i, abort_i,
    output instr_o, instr_pc_o, instr_abort_o, instr_valid_o,
    input  instr_ready_i,
    output count_o
  );

  // Memory controller / fetch stage / redirect source side
  modport slave (
    output flush_i, flush_pc_i,
    input  addr_o, trans_o, write_o, size_o, prot_o,
    output rdata_i, data_valid_i, abort_i,
    input  instr_o, instr_pc_o, instr_abort_o, instr_valid_o,
    output instr_ready_i,
    input  count_o
  );
endinterface

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word reads (one outstanding
// at a time), queues returned words with their PC and abort flag in a
// DEPTH-entry FIFO, and hands them to the fetch stage over valid/ready.
// A flush empties the FIFO and redirects fetching to the new PC.
module prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  prefetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HALT} state_t;

  state_t          state_reg;
  logic [31:0]     fetch_addr_reg;
  logic            nonseq_reg;
  logic [31:0]     addr_reg;
  logic [1:0]      trans_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [31:0]     data_mem  [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic            abort_mem [DEPTH];

  logic            push;
  logic            pop;
  logic            not_empty;
  logic            has_room;

  // A word is only accepted while its request is outstanding; a flush in the
  // same edge wins over both push and pop.
  assign not_empty = (count_reg != '0);
  assign push      = (state_reg == WAIT) && bus.data_valid_i && !bus.flush_i;
  assign pop       = not_empty && bus.instr_ready_i && !bus.flush_i;
  assign has_room  = (count_reg < CW'(DEPTH));

  // Request sequencing, redirect handling and FIFO bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      fetch_addr_reg <= RESET_PC;
      nonseq_reg     <= 1'b1;
      addr_reg       <= RESET_PC;
      trans_reg      <= TRANS_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else if (bus.flush_i) begin
      // A request still in flight must have its late word swallowed.
      if ((state_reg == WAIT && !bus.data_valid_i) || state_reg == DISCARD)
        state_reg <= DISCARD;
      else
        state_reg <= IDLE;
      fetch_addr_reg <= bus.flush_pc_i & ~32'h3;
      nonseq_reg     <= 1'b1;
      trans_reg      <= TRANS_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Only issue when the returned word is guaranteed a free slot.
          if (has_room) begin
            addr_reg   <= fetch_addr_reg;
            trans_reg  <= nonseq_reg ? TRANS_NONSEQ : TRANS_SEQ;
            nonseq_reg <= 1'b0;
            state_reg  <= WAIT;
          end else begin
            trans_reg <= TRANS_IDLE;
          end
        end
        WAIT: begin
          trans_reg <= TRANS_IDLE;
          if (bus.data_valid_i) begin
            if (bus.abort_i) begin
              state_reg <= HALT;
            end else begin
              fetch_addr_reg <= fetch_addr_reg + 32'd4;
              state_reg      <= IDLE;
            end
          end
        end
        DISCARD: begin
          trans_reg <= TRANS_IDLE;
          if (bus.data_valid_i)
            state_reg <= IDLE;
        end
        HALT: begin
          trans_reg <= TRANS_IDLE;
        end
      endcase

      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: each slot captures the returned word when the write
  // pointer selects it. The word is tagged with the address it was fetched from.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the returned word, its PC and its abort status.
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == AW'(gi)) begin
        data_mem[gi]  <= bus.rdata_i;
        pc_mem[gi]    <= fetch_addr_reg;
        abort_mem[gi] <= bus.abort_i;
      end
    end
  end

  // Head entry is forced to zero while empty so it is stable and clean.
  assign bus.instr_o       = not_empty ? data_mem[rd_ptr_reg]  : 32'h0;
  assign bus.instr_pc_o    = not_empty ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign bus.instr_abort_o = not_empty ? abort_mem[rd_ptr_reg] : 1'b0;
  assign bus.instr_valid_o = not_empty;
  assign bus.count_o       = count_reg;

  assign bus.addr_o  = addr_reg;
  assign bus.trans_o = trans_reg;
  assign bus.write_o = 1'b0;
  assign bus.size_o  = 1'b1;
  assign bus.prot_o  = 2'b00;
endmodule

// File: tb/tb_prefetch_buffer.sv
// Testbench for prefetch_buffer: a memory model answering one cycle after
// each request, a monitor logging requests and pops, expectation tables for
// the request/pop sequences, and directed sequences for flush/abort/reset.
module tb_prefetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          test;
    int          idx;
    logic [1:0]  trans;
    logic [31:0] addr;
  } tvec_t;

  typedef struct {
    int          test;
    int          idx;
    logic [31:0] pc;
    logic        abort;
  } pvec_t;

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
  } txn_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        abort;
  } pop_t;

  tvec_t tv[$];
  pvec_t pv[$];
  txn_t  trans_log[$];
  pop_t  pop_log[$];

  int checks   = 0;
  int failures = 0;

  logic        mem_manual = 1'b0;
  logic        abort_en   = 1'b0;
  logic [31:0] abort_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    mem_manual = 1'b0;
    abort_en = 1'b0;
    tick(2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    trans_log.delete();
    pop_log.delete();
  endtask

  // Advance until the nth request is visible on the bus (checked #1 after edge).
  task automatic wait_issue(input int nth, input int limit, input string name);
    int seen = 0;
    int cyc = 0;
    while (seen < nth && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.trans_o != 2'b00) seen++;
    end
    checks++;
    if (seen < nth) begin
      failures++;
      $display("FAIL %s: timeout, saw %0d of %0d requests", name, seen, nth);
    end else begin
      $display("ok   %s: request %0d seen after %0d cycles", name, nth, cyc);
    end
  endtask

  task automatic check_txns(input int t);
    foreach (tv[k]) begin
      if (tv[k].test == t) begin
        if (tv[k].idx < trans_log.size()) begin
          check($sformatf("t%0d_req%0d_trans", t, tv[k].idx), trans_log[tv[k].idx].trans, tv[k].trans);
          check($sformatf("t%0d_req%0d_addr", t, tv[k].idx), trans_log[tv[k].idx].addr, tv[k].addr);
        end else begin
          check($sformatf("t%0d_req%0d_present", t, tv[k].idx), 32'd0, 32'd1);
        end
      end
    end
  endtask

  task automatic check_pops(input int t);
    foreach (pv[k]) begin
      if (pv[k].test == t) begin
        if (pv[k].idx < pop_log.size()) begin
          check($sformatf("t%0d_pop%0d_pc", t, pv[k].idx), pop_log[pv[k].idx].pc, pv[k].pc);
          check($sformatf("t%0d_pop%0d_instr", t, pv[k].idx), pop_log[pv[k].idx].instr, mem_word(pv[k].pc));
          check($sformatf("t%0d_pop%0d_abort", t, pv[k].idx), 32'(pop_log[pv[k].idx].abort), 32'(pv[k].abort));
        end else begin
          check($sformatf("t%0d_pop%0d_present", t, pv[k].idx), 32'd0, 32'd1);
        end
      end
    end
  endtask

  // Memory model: returns the word one cycle after the request is seen.
  initial begin
    logic        p;
    logic [31:0] pa;
    bus.data_valid_i = 1'b0;
    bus.rdata_i      = 32'h0;
    bus.abort_i      = 1'b0;
    forever begin
      @(negedge clk);
      p  = (bus.trans_o != 2'b00) && !rst;
      pa = bus.addr_o;
      @(posedge clk);
      #1;
      if (!mem_manual) begin
        bus.data_valid_i = p;
        bus.rdata_i      = p ? mem_word(pa) : 32'h0;
        bus.abort_i      = p && abort_en && (pa == abort_addr);
      end
    end
  end

  // Monitor: log requests and accepted head entries mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.trans_o != 2'b00)
          trans_log.push_back('{bus.trans_o, bus.addr_o});
        if (bus.instr_valid_o && bus.instr_ready_i && !bus.flush_i)
          pop_log.push_back('{bus.instr_pc_o, bus.instr_o, bus.instr_abort_o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected request sequences
    tv.push_back('{1, 0, 2'b10, 32'h0});
    tv.push_back('{1, 1, 2'b11, 32'h4});
    tv.push_back('{1, 2, 2'b11, 32'h8});
    tv.push_back('{2, 0, 2'b10, 32'h0});
    tv.push_back('{2, 1, 2'b11, 32'h4});
    tv.push_back('{2, 2, 2'b11, 32'h8});
    tv.push_back('{2, 3, 2'b11, 32'hC});
    tv.push_back('{22, 4, 2'b11, 32'h10});
    // Expected pop sequences
    pv.push_back('{1, 0, 32'h0, 1'b0});
    pv.push_back('{1, 1, 32'h4, 1'b0});
    pv.push_back('{1, 2, 32'h8, 1'b0});
    pv.push_back('{4, 0, 32'h0, 1'b0});
    pv.push_back('{4, 1, 32'h4, 1'b0});
    pv.push_back('{4, 2, 32'h8, 1'b1});

    bus.flush_i       = 1'b0;
    bus.flush_pc_i    = 32'h0;
    bus.instr_ready_i = 1'b0;

    // Reset values
    rst = 1'b1;
    tick(3);
    check("rst_trans", bus.trans_o, 2'b00);
    check("rst_addr", bus.addr_o, RESET_PC);
    check("rst_count", bus.count_o, 0);
    check("rst_valid", bus.instr_valid_o, 0);
    check("rst_instr", bus.instr_o, 0);
    check("rst_pc", bus.instr_pc_o, 0);
    check("rst_abort", bus.instr_abort_o, 0);
    check("const_write", bus.write_o, 0);
    check("const_size", bus.size_o, 1);
    check("const_prot", bus.prot_o, 0);

    // 1: streaming with ready=1
    do_reset();
    bus.instr_ready_i = 1'b1;
    tick(20);
    check_txns(1);
    check_pops(1);

    // 2: back-pressure fills the FIFO, then a single-cycle ready pulse
    do_reset();
    tick(40);
    check("t2_nreq", trans_log.size(), 4);
    check_txns(2);
    check("t2_count_full", bus.count_o, 4);
    check("t2_trans_idle", bus.trans_o, 2'b00);
    check("t2_head_pc", bus.instr_pc_o, 32'h0);
    bus.instr_ready_i = 1'b1;
    tick(1);
    bus.instr_ready_i = 1'b0;
    tick(12);
    check("t2_nreq_after", trans_log.size(), 5);
    check_txns(22);
    check("t2_count_after", bus.count_o, 4);
    check("t2_head_pc_after", bus.instr_pc_o, 32'h4);
    check("t2_npop", pop_log.size(), 1);

    // 3: flush while waiting for a word
    do_reset();
    wait_issue(3, 40, "t3_third_req");
    check("t3_count_before", bus.count_o, 2);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h103;
    tick(1);
    bus.flush_i = 1'b0;
    check("t3_count_flushed", bus.count_o, 0);
    check("t3_valid_flushed", bus.instr_valid_o, 0);
    wait_issue(1, 10, "t3_redirect_req");
    check("t3_trans", bus.trans_o, 2'b10);
    check("t3_addr", bus.addr_o, 32'h100);
    check("t3_late_dropped", bus.count_o, 0);
    tick(3);
    check("t3_count_new", bus.count_o, 1);
    check("t3_head_pc", bus.instr_pc_o, 32'h100);
    check("t3_head_instr", bus.instr_o, mem_word(32'h100));

    // 4: abort halts fetching until a flush
    do_reset();
    abort_en   = 1'b1;
    abort_addr = 32'h8;
    tick(40);
    check("t4_nreq", trans_log.size(), 3);
    check("t4_count", bus.count_o, 3);
    bus.instr_ready_i = 1'b1;
    tick(2);
    bus.instr_ready_i = 1'b0;
    check("t4_head_pc", bus.instr_pc_o, 32'h8);
    check("t4_head_abort", bus.instr_abort_o, 1);
    bus.instr_ready_i = 1'b1;
    tick(1);
    bus.instr_ready_i = 1'b0;
    check_pops(4);
    check("t4_count_empty", bus.count_o, 0);
    tick(10);
    check("t4_halted", trans_log.size(), 3);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h40;
    tick(1);
    bus.flush_i = 1'b0;
    abort_en    = 1'b0;
    wait_issue(1, 10, "t4_redirect_req");
    check("t4_trans", bus.trans_o, 2'b10);
    check("t4_addr", bus.addr_o, 32'h40);

    // 5: flush wins over a simultaneous pop
    do_reset();
    for (int i = 0; i < 40 && bus.count_o < 2; i++) tick(1);
    check("t5_count_before", bus.count_o >= 2, 1);
    bus.instr_ready_i = 1'b1;
    bus.flush_i       = 1'b1;
    bus.flush_pc_i    = 32'h200;
    tick(1);
    bus.flush_i       = 1'b0;
    bus.instr_ready_i = 1'b0;
    check("t5_count", bus.count_o, 0);
    check("t5_valid", bus.instr_valid_o, 0);
    wait_issue(1, 10, "t5_redirect_req");
    check("t5_addr", bus.addr_o, 32'h200);

    // 6: asynchronous reset mid-WAIT, then a stale data strobe
    do_reset();
    wait_issue(3, 40, "t6_third_req");
    check("t6_count_before", bus.count_o, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_trans", bus.trans_o, 2'b00);
    check("t6_async_addr", bus.addr_o, RESET_PC);
    check("t6_async_count", bus.count_o, 0);
    check("t6_async_valid", bus.instr_valid_o, 0);
    check("t6_async_instr", bus.instr_o, 0);
    mem_manual       = 1'b1;
    bus.data_valid_i = 1'b1;
    bus.rdata_i      = 32'hDEAD_BEEF;
    bus.abort_i      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    check("t6_first_trans", bus.trans_o, 2'b10);
    check("t6_first_addr", bus.addr_o, RESET_PC);
    check("t6_stale_ignored", bus.count_o, 0);
    bus.data_valid_i = 1'b0;
    mem_manual       = 1'b0;
    tick(4);
    check("t6_count", bus.count_o, 1);
    check("t6_head_pc", bus.instr_pc_o, RESET_PC);
    check("t6_head_instr", bus.instr_o, mem_word(RESET_PC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
